// File: rtl/fetch_seq.sv
// fetch_seq: four-phase fetch/read/execute/writeback sequencer.
// It fetches one instruction word, reads two register operands, waits one
// cycle for the external ALU, then writes back or redirects the PC.
// An HLT instruction parks the sequencer until reset.
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          NREG     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [15:0] q,
  output logic [3:0]  ph,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] sr1,
  output logic [15:0] sr2,
  output logic        halt
);

  // One-hot phase encoding doubles as the ph output; all-zero means halted.
  typedef enum logic [3:0] {
    S_HALT = 4'b0000,
    S_PH0  = 4'b0001,
    S_PH1  = 4'b0010,
    S_PH2  = 4'b0100,
    S_PH3  = 4'b1000
  } phase_e;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LI  = 5'b00010;
  localparam logic [4:0] OP_B   = 5'b00011;
  localparam logic [4:0] OP_BNZ = 5'b00100;
  localparam logic [4:0] OP_HLT = 5'b11111;

  phase_e      state_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q;
  logic [15:0] sr1_q, sr2_q;
  logic        halt_q;
  logic [15:0] regs_q [NREG];

  logic [4:0]  op;
  logic [2:0]  rd, rs;
  logic [15:0] rd_val, rs_val;
  logic [15:0] pc_inc;
  logic        wr_en;

  assign op = ir_q[15:11];
  assign rd = ir_q[10:8];
  assign rs = ir_q[7:5];

  // Operand read; indices beyond the implemented register count read zero.
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    if (32'(rd) < NREG) rd_val = regs_q[rd];
    if (32'(rs) < NREG) rs_val = regs_q[rs];
  end

  // Sequential PC wraps naturally at 16 bits.
  assign pc_inc = pc_q + 16'd1;

  // Writeback PC selection; only meaningful in PH3.
  always_comb begin
    pc_d = pc_q;
    if (state_q == S_PH3) begin
      case (op)
        OP_B:    pc_d = q;
        OP_BNZ:  pc_d = (sr1_q != 16'h0000) ? q : pc_inc;
        OP_HLT:  pc_d = pc_q;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // Register file write only happens in PH3, so it never collides with the
  // PH1 operand read and no bypass path is required.
  assign wr_en = (state_q == S_PH3) && ((op == OP_ADD) || (op == OP_LI));

  // Register file: cleared on reset, written with the ALU result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en && (32'(rd) < NREG)) begin
      regs_q[rd] <= q;
    end
  end

  // Phase FSM with its architectural state (pc, ir, operands, halt).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_PH0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        // Fetch: hold until memory acknowledges, however long that takes.
        S_PH0: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= S_PH1;
          end
        end
        // Operand read; BNZ tests the rd operand via sr1.
        S_PH1: begin
          sr1_q   <= rd_val;
          sr2_q   <= rs_val;
          state_q <= S_PH2;
        end
        // Execute: the external ALU registers q on this edge.
        S_PH2: begin
          state_q <= S_PH3;
        end
        // Writeback / branch resolution.
        S_PH3: begin
          pc_q <= pc_d;
          if (op == OP_HLT) begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end else begin
            state_q <= S_PH0;
          end
        end
        // Halted stays halted; any corrupted encoding also parks here so
        // ph never shows a non-one-hot value.
        default: begin
          state_q <= S_HALT;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = (state_q == S_PH0) && !halt_q;
  assign imem_addr = pc_q;
  assign ph        = state_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign sr1       = sr1_q;
  assign sr2       = sr2_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: reset, stalls, LI/ADD/B/BNZ/NOP/HLT,
// pc wrap and asynchronous reset in mid-instruction.
module tb_fetch_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] q;
  logic [3:0]  ph;
  logic [15:0] pc, ir, sr1, sr2;
  logic        halt;

  int tests = 0;
  int fails = 0;

  fetch_seq #(.RESET_PC(16'h0000), .NREG(8)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .q(q), .ph(ph), .pc(pc), .ir(ir), .sr1(sr1), .sr2(sr2), .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Run one instruction from PH0 with immediate ack; ends back in PH0.
  task automatic exec(input logic [15:0] instr, input logic [15:0] qv);
    imem_ack = 1'b1; imem_data = instr;
    step(1);
    imem_ack = 1'b0; q = qv;
    step(3);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; imem_ack = 1'b0; imem_data = '0; q = '0;
    step(2);
    chk("rst_ph", ph, 16'h0001);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_sr1", sr1, 16'h0000);
    chk("rst_sr2", sr2, 16'h0000);
    chk("rst_halt", halt, 16'h0000);
    RST = 1'b0;
    #1;
    chk("rel_req", imem_req, 16'h0001);
    chk("rel_addr", imem_addr, 16'h0000);

    // LI r1, q=5
    imem_ack = 1'b1; imem_data = 16'h1105;
    step(1);
    chk("li_ph1", ph, 16'h0002);
    chk("li_ir", ir, 16'h1105);
    chk("li_req_off", imem_req, 16'h0000);
    imem_ack = 1'b0;
    step(1);
    chk("li_ph2", ph, 16'h0004);
    q = 16'h0005;
    step(1);
    chk("li_ph3", ph, 16'h0008);
    step(1);
    chk("li_ph0", ph, 16'h0001);
    chk("li_pc", pc, 16'h0001);
    chk("li_addr", imem_addr, 16'h0001);

    // Fetch stall of 3 cycles, then NOP rd=1 rs=1 to read R[1]
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_ph", ph, 16'h0001);
      chk("stall_req", imem_req, 16'h0001);
      chk("stall_addr", imem_addr, 16'h0001);
    end
    imem_ack = 1'b1; imem_data = 16'h0120;
    step(1);
    chk("stall_ph1", ph, 16'h0002);
    chk("stall_ir", ir, 16'h0120);
    // ack during PH1 must be ignored
    imem_data = 16'hFFFF;
    step(1);
    chk("ign_ir", ir, 16'h0120);
    chk("r1_sr1", sr1, 16'h0005);
    chk("r1_sr2", sr2, 16'h0005);
    imem_ack = 1'b0;
    step(2);
    chk("nop_pc", pc, 16'h0002);

    // LI r2=7; BNZ r0 (zero) falls through; BNZ r2 (7) taken
    exec(16'h1200, 16'h0007);
    chk("li2_pc", pc, 16'h0003);
    exec(16'h2000, 16'h0040);
    chk("bnz0_pc", pc, 16'h0004);
    exec(16'h2200, 16'h0040);
    chk("bnz7_pc", pc, 16'h0040);
    chk("bnz7_sr1", sr1, 16'h0007);

    // ADD r3 = 1234, then read back through NOP rd=3
    exec(16'h0B00, 16'h1234);
    chk("add_pc", pc, 16'h0041);
    exec(16'h0300, 16'h0000);
    chk("add_r3", sr1, 16'h1234);

    // B to FFFF, then NOP wraps pc to 0000
    exec(16'h1800, 16'hFFFF);
    chk("b_pc", pc, 16'hFFFF);
    exec(16'h0000, 16'h0000);
    chk("wrap_pc", pc, 16'h0000);

    // HLT
    exec(16'hF800, 16'h0123);
    chk("hlt_ph", ph, 16'h0000);
    chk("hlt_halt", halt, 16'h0001);
    chk("hlt_req", imem_req, 16'h0000);
    chk("hlt_pc", pc, 16'h0000);
    imem_ack = 1'b1; imem_data = 16'h1105;
    for (int i = 0; i < 4; i++) begin
      step(1);
      imem_ack = ~imem_ack;
      chk("hlt_stay_ph", ph, 16'h0000);
      chk("hlt_stay_req", imem_req, 16'h0000);
      chk("hlt_stay_ir", ir, 16'hF800);
    end
    imem_ack = 1'b0;
    RST = 1'b1;
    #1;
    chk("hrst_ph", ph, 16'h0001);
    chk("hrst_halt", halt, 16'h0000);
    chk("hrst_ir", ir, 16'h0000);
    step(1);
    RST = 1'b0;
    #1;

    // NOP to move pc to 1, then ADD r1 interrupted by reset in PH2
    exec(16'h0000, 16'h0000);
    chk("pre_pc", pc, 16'h0001);
    imem_ack = 1'b1; imem_data = 16'h0900;
    step(1);
    imem_ack = 1'b0; q = 16'hBEEF;
    step(1);
    chk("add_ph2", ph, 16'h0004);
    RST = 1'b1;
    #1;
    chk("mid_ph", ph, 16'h0001);
    chk("mid_pc", pc, 16'h0000);
    step(1);
    RST = 1'b0;
    #1;
    chk("mid_req", imem_req, 16'h0001);
    // R[1] must read zero: cleared by reset and not written by the aborted ADD
    exec(16'h0100, 16'h0000);
    chk("mid_r1", sr1, 16'h0000);
    chk("mid_pc2", pc, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
